// File: rtl/sync_fifo_generic.sv
// Synchronous FIFO on an inferred sync-read RAM with binary wrapping pointers.
// FWFT=1 prefetches the head word into the output register; FWFT=0 is a standard read port.
module sync_fifo_generic #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2048,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [WIDTH-1:0]           dout,
    input  logic                       rd_en,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       valid,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     dcnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    dcnt_q, dcnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full_i, empty_i;
    logic             wr_acc, rd_acc, dout_ld;
    logic [CW-1:0]    ram_cnt;

    assign full_i  = (dcnt_q == DEPTH_C);
    assign empty_i = (FWFT != 0) ? ~valid_q : (dcnt_q == '0);
    assign wr_acc  = wr_en & ~full_i;
    assign rd_acc  = rd_en & ~empty_i;

    // Words still in RAM, i.e. not already parked in the output register.
    assign ram_cnt = dcnt_q - {{(CW-1){1'b0}}, valid_q};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dcnt_d      = dcnt_q;
        valid_d     = 1'b0;
        dout_ld     = 1'b0;
        overflow_d  = wr_en & full_i;
        underflow_d = rd_en & empty_i;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   dcnt_d = dcnt_q + CW'(1);
            2'b01:   dcnt_d = dcnt_q - CW'(1);
            default: dcnt_d = dcnt_q;
        endcase

        if (FWFT != 0) begin
            dout_ld = (ram_cnt != '0) && (~valid_q || rd_acc);
            valid_d = dout_ld | (valid_q & ~rd_acc);
        end else begin
            dout_ld = rd_acc;
            valid_d = rd_acc;
        end

        if (dout_ld) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        dout_d = dout_ld ? mem[rd_ptr_q] : dout_q;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dcnt_q      <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dcnt_q      <= dcnt_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign full         = full_i;
    assign almost_full  = (dcnt_q >= AF_C);
    assign almost_empty = (dcnt_q <= AE_C);
    assign empty        = empty_i;
    assign valid        = valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign dout         = dout_q;
    assign dcnt         = dcnt_q;

endmodule
